aes128dec_inv_key_sched: RTL and testbench
==========================================

// Module: aes128dec_inv_key_sched
// PURPOSE
//  Inverse AES-128 key schedule for the decrypt datapath. Takes the round-10 key and streams
//  round keys 10..0 (decrypt order) over a valid/ready port, one inverse expansion step per key.
//  Rcon comes from a 1-cycle synchronous ROM. Sits between the key-load CSR and the InvCipher rounds.
// PARAMETERS
//  NR        10   number of rounds; fixed to 10 for AES-128, other values unsupported
//  KEY_W     128  round-key width in bits
//  IDX_W     4    width of rk_idx and the Rcon ROM address
// PORTS
//  clk       in   1    rising-edge clock
//  reset_n   in   1    asynchronous active-low reset
//  start     in   1    load key_in and begin a schedule; sampled only in IDLE
//  abort     in   1    synchronous abort; to IDLE next cycle, no done pulse
//  key_in    in   128  round-10 key (cipher key when AES128DEC_FWD_EXPAND_EN), word0 = [127:96]
//  busy      out  1    high from the cycle after accepted start until DONE exits
//  rk_valid  out  1    rk_out/rk_idx valid
//  rk_ready  in   1    consumer accepts the key when rk_valid && rk_ready
//  rk_out    out  128  current round key
//  rk_idx    out  4    round number of rk_out, 10 down to 0
//  done      out  1    one-cycle pulse after the round-0 key is accepted
// BEHAVIOUR
//  Reset: state=IDLE; busy, rk_valid, done = 0; rk_out = 0; rk_idx = 0; ROM ce = 0.
//  FSM states: IDLE, [FWD_RD, FWD_CALC], EMIT, CALC, DONE.
//  IDLE: on start, latch key_in into rk_q and set idx=10 -> EMIT. start is ignored outside IDLE.
//  EMIT: rk_valid=1. rk_out and rk_idx hold stable until handshake.
//   On handshake with idx==0 -> DONE.
//   On handshake with idx!=0: assert ROM ce, addr=idx-1 -> CALC.
//  CALC: ROM q is valid this cycle. With words w0..w3 of rk_q:
//   w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^{rcon,24'h0}.
//   rk_q<=w0'..w3'; idx<=idx-1 -> EMIT.
//  DONE: done=1 for one cycle, busy=0 next cycle -> IDLE.
//  Latency with rk_ready tied high:
//   first rk_valid in cycle start+1; successive keys 2 cycles apart.
//   done asserted in cycle start+22; 11 handshakes total.
//  Back-pressure: rk_ready low in EMIT stalls indefinitely; no key is dropped or repeated.
//  abort: beats every state except IDLE -> IDLE next cycle; rk_valid=0, busy=0, no done.
//   abort and start together in IDLE: start ignored.
//  Mid-operation reset: async clear to reset values; any partial stream is discarded.
//  All XOR and S-box logic is pure GF(2^8)/bitwise; there is no arithmetic carry.
//  ROM: 10 x 8-bit, content 01,02,04,08,10,20,40,80,1b,36.
// CONFIGURATION
//  AES128DEC_FWD_EXPAND_EN defined:
//   key_in is the cipher key. IDLE -> FWD_RD; the block runs 10 forward steps (r=0..9).
//   FWD_RD: ce, addr=r. FWD_CALC: apply the FIPS-197 forward step.
//   After step 9, idx=10 -> EMIT; first rk_valid in cycle start+21.
//   busy is high throughout; abort behaves the same in FWD states.
//  Not defined: FWD states are absent and key_in must be the round-10 key.
// STRUCTURE
//  Package aes128_pkg: SBOX[256] constant, RCON[10] constant, round_key_t (logic [127:0]),
//   the state enum, and functions sub_word/rot_word.
//  Sub-module aes128dec_rcon_rom: sync 1R ROM with ports address0/ce0/q0/reset/clk, q0 registered on ce0.
//  The S-box is a combinational function of the package, not a module.
// TESTING
//  1 FIPS-197 A.1: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, start, rk_ready=1.
//    -> idx10=d014..0ca6, idx9=ac7766f319fadc2128d12941575c006e,
//       idx0=2b7e151628aed2a6abf7158809cf4f3c; done at start+22.
//  2 Back-pressure: rk_ready low 5 cycles at idx 7, then random toggling.
//    -> identical key sequence to test 1; rk_out stable while rk_valid && !rk_ready.
//  3 abort at idx 4 -> rk_valid=0 and busy=0 next cycle, no done.
//    A following start then reproduces test 1 fully.
//  4 start pulsed while busy, and start coincident with abort in IDLE -> both ignored,
//    sequence unchanged / state stays IDLE.
//  5 reset_n low mid-stream (idx 6, async, between edges) -> all outputs reset immediately.
//    A new start after release produces the full sequence.
//  6 AES128DEC_FWD_EXPAND_EN: key_in=2b7e151628aed2a6abf7158809cf4f3c
//    -> first key d014f9a8c9ee2589e13f0cc8b6630ca6 at start+21, rest as test 1.

Source files
------------

// File: rtl/aes128_pkg.sv
// AES-128 tables, round-key type, FSM state codes and word helpers shared by the
// inverse key schedule and its round-constant ROM.
package aes128_pkg;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef logic [127:0] round_key_t;
    typedef logic [2:0]   state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_FWD_RD   = 3'd1;
    localparam state_t ST_FWD_CALC = 3'd2;
    localparam state_t ST_EMIT     = 3'd3;
    localparam state_t ST_CALC     = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = SBOX[w[i*8 +: 8]];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128dec_rcon_rom.sv
// Round-constant ROM, 10 x 8-bit, single read port with a registered output
// that only updates when ce0 is high.
module aes128dec_rcon_rom
    import aes128_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] address0,
    input  logic          ce0,
    output logic [7:0]    q0
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q0 <= 8'h00;
        end else if (ce0) begin
            // Addresses past the table read as zero rather than aliasing.
            q0 <= (int'(address0) < 10) ? RCON[address0] : 8'h00;
        end
    end

endmodule

// File: rtl/aes128dec_inv_key_sched.sv
// Inverse AES-128 key schedule: streams round keys 10..0 over valid/ready.
// Define AES128DEC_FWD_EXPAND_EN to accept the cipher key and forward-expand it first.
module aes128dec_inv_key_sched
    import aes128_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [IDX_W-1:0] rk_idx,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t           state_reg, state_next;
    round_key_t       rk_reg, rk_next;
    logic [IDX_W-1:0] idx_reg, idx_next;

    logic             rom_ce;
    logic [IDX_W-1:0] rom_addr;
    logic [7:0]       rom_q;
    logic             rom_reset;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] inv_w0, inv_w1, inv_w2, inv_w3;
    logic [31:0] rcon_word;
    logic        handshake;

    assign {w0, w1, w2, w3} = rk_reg;
    assign rcon_word        = {rom_q, 24'h0};

    // Undo one forward step: recover old w3 first, since the S-box term depends on it.
    assign inv_w3 = w3 ^ w2;
    assign inv_w2 = w2 ^ w1;
    assign inv_w1 = w1 ^ w0;
    assign inv_w0 = w0 ^ sub_word(rot_word(inv_w3)) ^ rcon_word;

`ifdef AES128DEC_FWD_EXPAND_EN
    logic [31:0] fwd_w0, fwd_w1, fwd_w2, fwd_w3;

    assign fwd_w0 = w0 ^ sub_word(rot_word(w3)) ^ rcon_word;
    assign fwd_w1 = w1 ^ fwd_w0;
    assign fwd_w2 = w2 ^ fwd_w1;
    assign fwd_w3 = w3 ^ fwd_w2;
`endif

    assign busy      = (state_reg != ST_IDLE);
    assign rk_valid  = (state_reg == ST_EMIT);
    assign done      = (state_reg == ST_DONE);
    assign rk_out    = rk_reg;
    assign rk_idx    = idx_reg;
    assign handshake = rk_valid && rk_ready;
    assign rom_reset = ~reset_n;

    always_comb begin
        state_next = state_reg;
        rk_next    = rk_reg;
        idx_next   = idx_reg;
        rom_ce     = 1'b0;
        rom_addr   = '0;

        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        rk_next = key_in;
`ifdef AES128DEC_FWD_EXPAND_EN
                        idx_next   = '0;
                        state_next = ST_FWD_RD;
`else
                        idx_next   = LAST_IDX;
                        state_next = ST_EMIT;
`endif
                    end
                end
`ifdef AES128DEC_FWD_EXPAND_EN
                // idx_reg counts forward steps r here; Rcon for step r sits at address r.
                ST_FWD_RD: begin
                    rom_ce     = 1'b1;
                    rom_addr   = idx_reg;
                    state_next = ST_FWD_CALC;
                end
                ST_FWD_CALC: begin
                    rk_next = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
                    if (idx_reg == LAST_IDX - ONE) begin
                        idx_next   = LAST_IDX;
                        state_next = ST_EMIT;
                    end else begin
                        idx_next   = idx_reg + ONE;
                        state_next = ST_FWD_RD;
                    end
                end
`endif
                ST_EMIT: begin
                    if (handshake) begin
                        if (idx_reg == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            rom_ce     = 1'b1;
                            rom_addr   = idx_reg - ONE;
                            state_next = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rk_next    = {inv_w0, inv_w1, inv_w2, inv_w3};
                    idx_next   = idx_reg - ONE;
                    state_next = ST_EMIT;
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            rk_reg    <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rk_reg    <= rk_next;
            idx_reg   <= idx_next;
        end
    end

    aes128dec_rcon_rom #(
        .AW(IDX_W)
    ) u_rcon_rom (
        .clk      (clk),
        .reset    (rom_reset),
        .address0 (rom_addr),
        .ce0      (rom_ce),
        .q0       (rom_q)
    );

endmodule

// File: tb/tb_aes128dec_inv_key_sched.sv
// Bench for aes128dec_inv_key_sched: reference model derives S-box and Rcon from GF(2^8)
// arithmetic and runs the full FIPS-197 key expansion. Honours AES128DEC_FWD_EXPAND_EN.
module tb_aes128dec_inv_key_sched;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         rk_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;

    always #5 clk = ~clk;

    aes128dec_inv_key_sched dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

`ifdef AES128DEC_FWD_EXPAND_EN
    localparam int FIRST = 21;
`else
    localparam int FIRST = 1;
`endif
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int checks = 0;
    int passes = 0;

    logic [7:0]   sb [0:255];
    logic [7:0]   rc [0:9];
    logic [127:0] exp_rk [0:10];

    logic [127:0] q_key [$];
    int           q_idx [$];
    int           first_k, done_k, done_cnt, unstable;
    bit           timed_out, busy_first;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        r = 8'h01;
        for (int i = 0; i < 10; i++) begin
            rc[i] = r;
            r = gmul(r, 8'h02);
        end
    endtask

    task automatic model_expand(input logic [127:0] cipher);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = cipher[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_start(input logic [127:0] cipher);
        model_expand(cipher);
        @(negedge clk);
`ifdef AES128DEC_FWD_EXPAND_EN
        key_in = cipher;
`else
        key_in = exp_rk[10];
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // mode 0: ready high; 1: low 5 cycles at idx 7 then random; 2: random.
    // Stops at done, at a timeout, or when idx stop_idx is first presented.
    task automatic collect(input int mode, input int stop_idx, input bit spam_start);
        int           k, low_left;
        bit           low_done, prev_hold;
        logic [127:0] held;
        k = 0; low_left = 0; low_done = 0; prev_hold = 0; held = '0;
        q_key.delete(); q_idx.delete();
        first_k = -1; done_k = -1; done_cnt = 0; unstable = 0; timed_out = 0; busy_first = 0;
        while (1) begin
            @(negedge clk);
            k++;
            if (k > 3000) begin timed_out = 1; break; end
            if (k == 1) busy_first = busy;
            if (prev_hold && (rk_out !== held || rk_valid !== 1'b1)) unstable++;
            if (done) begin done_cnt++; done_k = k; break; end
            if (rk_valid && first_k < 0) first_k = k;
            if (rk_valid && stop_idx >= 0 && int'(rk_idx) == stop_idx) begin
                rk_ready = 1'b0;
                break;
            end
            case (mode)
                0: rk_ready = 1'b1;
                1: begin
                    if (rk_valid && rk_idx == 4'd7 && !low_done) begin low_left = 5; low_done = 1; end
                    if (low_left > 0) begin rk_ready = 1'b0; low_left--; end
                    else if (low_done) rk_ready = 1'($urandom_range(0, 1));
                    else rk_ready = 1'b1;
                end
                default: rk_ready = 1'($urandom_range(0, 1));
            endcase
            start = spam_start && busy;
            if (rk_valid && rk_ready) begin
                q_key.push_back(rk_out);
                q_idx.push_back(int'(rk_idx));
                $display("  key accepted idx=%0d key=%h cycle=start+%0d", rk_idx, rk_out, k);
            end
            prev_hold = rk_valid && !rk_ready;
            held = rk_out;
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, rk_valid, done, rk_idx, rk_out} !== '0)
            $display("FAIL reset_state got busy=%b valid=%b done=%b idx=%0d key=%h expected all zero",
                     busy, rk_valid, done, rk_idx, rk_out);
        else passes++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips();
        int bad;
        logic [127:0] g0, g1, g10;
        do_start(FIPS_KEY);
        collect(0, -1, 0);
        g0  = (q_key.size() > 0)  ? q_key[0]  : 'x;
        g1  = (q_key.size() > 1)  ? q_key[1]  : 'x;
        g10 = (q_key.size() > 10) ? q_key[10] : 'x;
        checks++;
        if (busy_first !== 1'b1) $display("FAIL t1_busy got %b expected 1", busy_first); else passes++;
        checks++;
        if (first_k != FIRST) $display("FAIL t1_first_valid got start+%0d expected start+%0d", first_k, FIRST);
        else passes++;
        checks++;
        if (g0 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("FAIL t1_idx10 got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", g0);
        else passes++;
        checks++;
        if (g1 !== 128'hac7766f319fadc2128d12941575c006e)
            $display("FAIL t1_idx9 got %h expected ac7766f319fadc2128d12941575c006e", g1);
        else passes++;
        checks++;
        if (g10 !== FIPS_KEY) $display("FAIL t1_idx0 got %h expected %h", g10, FIPS_KEY); else passes++;
        checks++;
        if (done_k != FIRST + 21) $display("FAIL t1_done_time got start+%0d expected start+%0d", done_k, FIRST + 21);
        else passes++;
        checks++; bad = (timed_out || q_key.size() != 11) ? 99 : -1;
        for (int i = 0; i < 11 && bad < 0; i++) if (q_key[i] !== exp_rk[10-i] || q_idx[i] != 10 - i) bad = i;
        if (bad == 99) $display("FAIL t1_seq got %0d keys timeout=%0d expected 11 keys", q_key.size(), timed_out);
        else if (bad >= 0) $display("FAIL t1_seq entry %0d got idx=%0d key=%h expected idx=%0d key=%h",
                                    bad, q_idx[bad], q_key[bad], 10 - bad, exp_rk[10-bad]);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL t1_after_done got done=%b busy=%b expected 0 0", done, busy);
        else passes++;
    endtask

    task automatic test_back_pressure();
        int bad;
        do_start(FIPS_KEY);
        collect(1, -1, 0);
        checks++;
        if (unstable != 0) $display("FAIL t2_stall_stable got %0d changes while stalled expected 0", unstable);
        else passes++;
        checks++; bad = (timed_out || q_key.size() != 11) ? 99 : -1;
        for (int i = 0; i < 11 && bad < 0; i++) if (q_key[i] !== exp_rk[10-i] || q_idx[i] != 10 - i) bad = i;
        if (bad == 99) $display("FAIL t2_seq got %0d keys timeout=%0d expected 11 keys", q_key.size(), timed_out);
        else if (bad >= 0) $display("FAIL t2_seq entry %0d got idx=%0d key=%h expected idx=%0d key=%h",
                                    bad, q_idx[bad], q_key[bad], 10 - bad, exp_rk[10-bad]);
        else passes++;
    endtask

    task automatic test_abort();
        int bad, seen_done;
        bit stayed_idle;
        do_start(FIPS_KEY);
        collect(0, 4, 0);
        checks++;
        if (timed_out || rk_idx !== 4'd4) $display("FAIL t3_reach_idx4 got idx=%0d timeout=%0d expected idx=4", rk_idx, timed_out);
        else passes++;
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t3_abort got valid=%b busy=%b expected 0 0", rk_valid, busy);
        else passes++;
        seen_done = 0; stayed_idle = 1;
        for (int i = 0; i < 6; i++) begin
            if (done) seen_done++;
            if (busy) stayed_idle = 0;
            @(negedge clk);
        end
        checks++;
        if (seen_done != 0 || !stayed_idle) $display("FAIL t3_no_done got done_pulses=%0d idle=%0d expected 0 1", seen_done, stayed_idle);
        else passes++;
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        collect(0, -1, 0);
        checks++;
        if (done_k != FIRST + 21) $display("FAIL t3_restart_done got start+%0d expected start+%0d", done_k, FIRST + 21);
        else passes++;
        checks++; bad = (timed_out || q_key.size() != 11) ? 99 : -1;
        for (int i = 0; i < 11 && bad < 0; i++) if (q_key[i] !== exp_rk[10-i] || q_idx[i] != 10 - i) bad = i;
        if (bad == 99) $display("FAIL t3_seq got %0d keys timeout=%0d expected 11 keys", q_key.size(), timed_out);
        else if (bad >= 0) $display("FAIL t3_seq entry %0d got idx=%0d key=%h expected idx=%0d key=%h",
                                    bad, q_idx[bad], q_key[bad], 10 - bad, exp_rk[10-bad]);
        else passes++;
    endtask

    task automatic test_start_ignored();
        int bad;
        bit stayed_idle;
        do_start(FIPS_KEY);
        collect(0, -1, 1);
        checks++;
        if (done_k != FIRST + 21) $display("FAIL t4_done_time got start+%0d expected start+%0d", done_k, FIRST + 21);
        else passes++;
        checks++; bad = (timed_out || q_key.size() != 11) ? 99 : -1;
        for (int i = 0; i < 11 && bad < 0; i++) if (q_key[i] !== exp_rk[10-i] || q_idx[i] != 10 - i) bad = i;
        if (bad == 99) $display("FAIL t4_seq got %0d keys timeout=%0d expected 11 keys", q_key.size(), timed_out);
        else if (bad >= 0) $display("FAIL t4_seq entry %0d got idx=%0d key=%h expected idx=%0d key=%h",
                                    bad, q_idx[bad], q_key[bad], 10 - bad, exp_rk[10-bad]);
        else passes++;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        stayed_idle = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || rk_valid) stayed_idle = 0;
        end
        checks++;
        if (!stayed_idle) $display("FAIL t4_start_abort got busy=%b valid=%b expected idle", busy, rk_valid);
        else passes++;
    endtask

    task automatic test_async_reset();
        int bad;
        do_start({$urandom(), $urandom(), $urandom(), $urandom()});
        collect(0, 6, 0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, rk_valid, done, rk_idx, rk_out} !== '0)
            $display("FAIL t5_async_reset got busy=%b valid=%b done=%b idx=%0d key=%h expected all zero",
                     busy, rk_valid, done, rk_idx, rk_out);
        else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        rk_ready = 1'b1;
        do_start({$urandom(), $urandom(), $urandom(), $urandom()});
        collect(0, -1, 0);
        checks++; bad = (timed_out || q_key.size() != 11) ? 99 : -1;
        for (int i = 0; i < 11 && bad < 0; i++) if (q_key[i] !== exp_rk[10-i] || q_idx[i] != 10 - i) bad = i;
        if (bad == 99) $display("FAIL t5_seq got %0d keys timeout=%0d expected 11 keys", q_key.size(), timed_out);
        else if (bad >= 0) $display("FAIL t5_seq entry %0d got idx=%0d key=%h expected idx=%0d key=%h",
                                    bad, q_idx[bad], q_key[bad], 10 - bad, exp_rk[10-bad]);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int bad;
        for (int n = 0; n < 3; n++) begin
            do_start({$urandom(), $urandom(), $urandom(), $urandom()});
            collect(2, -1, 0);
            checks++;
            if (unstable != 0) $display("FAIL t7_stall_stable run %0d got %0d changes expected 0", n, unstable);
            else passes++;
            checks++; bad = (timed_out || q_key.size() != 11) ? 99 : -1;
            for (int i = 0; i < 11 && bad < 0; i++) if (q_key[i] !== exp_rk[10-i] || q_idx[i] != 10 - i) bad = i;
            if (bad == 99) $display("FAIL t7_seq run %0d got %0d keys timeout=%0d expected 11 keys", n, q_key.size(), timed_out);
            else if (bad >= 0) $display("FAIL t7_seq run %0d entry %0d got idx=%0d key=%h expected idx=%0d key=%h",
                                        n, bad, q_idx[bad], q_key[bad], 10 - bad, exp_rk[10-bad]);
            else passes++;
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_fips();
        test_back_pressure();
        test_abort();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got time limit reached expected bench completion");
        $fatal(1, "watchdog");
    end

endmodule
